// File: rtl/verif_rx_checker_pkg.sv
// Shared types and helpers for the receive-side checker.
// Contents: error-bit enumeration, sequence-table entry, packet-id decode.
package verif_rx_checker_pkg;

  // Widest sequence value the table stores; narrower ids are zero-extended.
  localparam int unsigned SEQ_MAX_W = 64;

  // Bit positions inside err_flags.
  typedef enum logic [1:0] {
    ERR_DEST  = 2'd0,
    ERR_SELF  = 2'd1,
    ERR_ORDER = 2'd2
  } chk_err_e;

  typedef struct packed {
    logic                 valid;
    logic [SEQ_MAX_W-1:0] seq;
  } seq_entry_s;

  typedef struct packed {
    logic [SEQ_MAX_W-1:0] src;
    logic [SEQ_MAX_W-1:0] seq;
  } pkt_id_s;

  // src = id mod n, seq = id div n; n is a power of two.
  function automatic pkt_id_s decode_pkt_id(input logic [SEQ_MAX_W-1:0] id,
                                            input int unsigned          n);
    pkt_id_s r;
    r.src = id & (SEQ_MAX_W'(n) - SEQ_MAX_W'(1));
    r.seq = id >> $clog2(n);
    return r;
  endfunction

endpackage

// File: rtl/verif_rx_checker_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr.
// Ports: req (requests), ptr (start index) -> grant (one-hot), idx (index), any (a grant exists).
module rr_arbiter #(
  parameter  int unsigned W  = 2,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [W-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan W positions starting at ptr, wrapping modulo W.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!any && req[(32'(ptr) + i) % W]) begin
        any                        = 1'b1;
        grant[(32'(ptr) + i) % W]  = 1'b1;
        idx                        = IW'((32'(ptr) + i) % W);
      end
    end
  end

endmodule

// File: rtl/verif_rx_checker.sv
// Receive-side sink/scoreboard for one client endpoint.
// Drains at most one flit per cycle across VCs, drives random per-VC backpressure,
// checks destination, self-origin and per-(src,VC) ordering, and exports counters.
// Ports: clk, rst (sync active-low), i_v/i_d (per-VC valid and {last,addr,data} flits),
//        o_b (per-VC backpressure), bp_rate (stall percent, sampled in reset),
//        rx_count, err_count, err_flags {ORDER,SELF,DEST}, err_src, err_vc.
module verif_rx_checker
  import verif_rx_checker_pkg::*;
#(
  parameter  int unsigned N         = 16,
  parameter  int unsigned D_W       = 32,
  parameter  int unsigned A_W       = 4,
  parameter  int unsigned VC_W      = 2,
  parameter  int unsigned POSX      = 0,
  parameter  logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int unsigned VC_IW     = (VC_W > 1) ? $clog2(VC_W) : 1,
  localparam int unsigned FLIT_W    = A_W + D_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VC_W-1:0]          i_v,
  input  logic [VC_W*FLIT_W-1:0]   i_d,
  output logic [VC_W-1:0]          o_b,
  input  logic [6:0]               bp_rate,
  output logic [31:0]              rx_count,
  output logic [15:0]              err_count,
  output logic [2:0]               err_flags,
  output logic [A_W-1:0]           err_src,
  output logic [VC_IW-1:0]         err_vc
);

  localparam int unsigned SRC_W = $clog2(N);
  localparam int unsigned PAY_W = A_W + D_W;

  // ---------------- stall generation ----------------
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [6:0]  bp_q;
  logic        stall;

  // Right-shifting Galois form, taps 16,14,13,11.
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Stall is registered from the current LFSR value, so it lags the LFSR by a cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr  <= LFSR_SEED;
      bp_q  <= bp_rate;
      stall <= (LFSR_SEED[6:0] % 7'd100) < bp_rate;
    end else begin
      lfsr  <= lfsr_nxt;
      stall <= (lfsr[6:0] % 7'd100) < bp_q;
    end
  end

  // ---------------- arbitration ----------------
  logic [VC_IW-1:0]  rr_ptr;
  logic [VC_W-1:0]   gnt;
  logic [VC_IW-1:0]  gnt_idx;
  logic              gnt_any;
  logic              accept;
  logic [FLIT_W-1:0] sel_flit;
  logic              unused_last;

  rr_arbiter #(.W(VC_W)) u_arb (
    .req   (i_v),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Only the granted lane can see stall; every other lane is held.
  always_comb begin
    o_b = '1;
    if (rst && gnt_any) o_b = ~gnt | {VC_W{stall}};
  end

  always_comb begin
    accept      = rst & gnt_any & ~stall;
    sel_flit    = i_d[32'(gnt_idx) * FLIT_W +: FLIT_W];
    unused_last = sel_flit[FLIT_W-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_idx == VC_IW'(VC_W - 1)) ? '0 : gnt_idx + VC_IW'(1);
    end
  end

  // ---------------- S1 register ----------------
  logic             s1_v;
  logic [PAY_W-1:0] s1_pay;
  logic [VC_IW-1:0] s1_vc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v   <= 1'b0;
      s1_pay <= '0;
      s1_vc  <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_pay <= sel_flit[PAY_W-1:0];
        s1_vc  <= gnt_idx;
      end
    end
  end

  // ---------------- checks ----------------
  seq_entry_s       seq_tbl [N][VC_W];
  pkt_id_s          dec;
  seq_entry_s       entry;
  logic [SRC_W-1:0] s1_src;
  logic [A_W-1:0]   s1_addr;
  logic [2:0]       errs;
  logic             tbl_we;

  always_comb begin
    s1_addr         = s1_pay[PAY_W-1:D_W];
    dec             = decode_pkt_id(SEQ_MAX_W'(s1_pay[D_W-1:0]), N);
    s1_src          = dec.src[SRC_W-1:0];
    entry           = seq_tbl[s1_src][s1_vc];
    errs            = '0;
    errs[ERR_DEST]  = (s1_addr != A_W'(POSX));
    errs[ERR_SELF]  = (dec.src == SEQ_MAX_W'(POSX));
    errs[ERR_ORDER] = entry.valid && (dec.seq <= entry.seq);
    tbl_we          = s1_v && (s1_addr == A_W'(POSX));
  end

  // Entry is rewritten even after an order error, resynchronising the stream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < N; s++)
        for (int unsigned v = 0; v < VC_W; v++)
          seq_tbl[s][v] <= '0;
    end else if (tbl_we) begin
      seq_tbl[s1_src][s1_vc] <= {1'b1, dec.seq};
    end
  end

  // ---------------- counters and first-error capture ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_count  <= '0;
      err_count <= '0;
      err_flags <= '0;
      err_src   <= '0;
      err_vc    <= '0;
    end else if (s1_v) begin
      rx_count <= rx_count + 32'd1;
      if (|errs) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        err_flags <= err_flags | errs;
        if (err_flags == 3'b000) begin
          err_src <= A_W'(s1_src);
          err_vc  <= s1_vc;
        end
      end
    end
  end

endmodule
